// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, shift-amount width, shift op encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    // 2'b11 is reserved; the shifter decodes it as SH_SLL.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_op_t;

endpackage

// File: rtl/shift_right_core.sv
// Combinational XLEN-bit logarithmic right shifter; vacated MSBs take fill_i.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
module shift_right_core #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               fill_i,
    output logic [XLEN-1:0]    data_o
);

    // stage_dat[s] is the operand after the first s power-of-two steps.
    logic [XLEN-1:0] stage_dat [SHAMT_W+1];

    assign stage_dat[0] = data_i;

    // Each stage either passes through or shifts right by 2**s, filling from the top.
    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int STEP = 1 << s;
        assign stage_dat[s+1] = shamt_i[s]
                              ? {{STEP{fill_i}}, stage_dat[s][XLEN-1:STEP]}
                              : stage_dat[s];
    end

    assign data_o = stage_dat[SHAMT_W];

endmodule

// File: rtl/shifter.sv
// Registered RV32I barrel shifter (SLL/SRL/SRA) sharing one right-shift core.
// Latency: 1 cycle from in_valid to out_valid/aluout.
// Backpressure: none; accepts an operation every cycle, aluout holds when idle.
module shifter #(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [1:0]      shift_op,
    input  logic [XLEN-1:0] alumux1_out,
    input  logic [XLEN-1:0] alumux2_out,
    output logic [XLEN-1:0] aluout,
    output logic            out_valid
);

    import alu_pkg::*;

    logic               is_left;
    logic               fill;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    opnd_rev;
    logic [XLEN-1:0]    core_in;
    logic [XLEN-1:0]    core_out;
    logic [XLEN-1:0]    core_out_rev;
    logic [XLEN-1:0]    result;

    logic [XLEN-1:0]    aluout_d, aluout_q;
    logic               out_valid_d, out_valid_q;

    // Amount bits above the shamt field are architecturally ignored.
    logic               unused_shamt_hi;
    assign unused_shamt_hi = ^alumux2_out[XLEN-1:SHAMT_W];

    assign shamt = alumux2_out[SHAMT_W-1:0];

    // Op decode: left shift for SLL and the reserved code, sign fill only for SRA.
    always_comb begin
        is_left = 1'b1;
        fill    = 1'b0;
        case (shift_op)
            SH_SRL: begin
                is_left = 1'b0;
            end
            SH_SRA: begin
                is_left = 1'b0;
                fill    = alumux1_out[XLEN-1];
            end
            default: begin
                is_left = 1'b1;
            end
        endcase
    end

    // Left shift = reverse, right shift with zero fill, reverse back.
    for (genvar i = 0; i < XLEN; i++) begin : g_rev
        assign opnd_rev[i]     = alumux1_out[XLEN-1-i];
        assign core_out_rev[i] = core_out[XLEN-1-i];
    end

    assign core_in = is_left ? opnd_rev : alumux1_out;

    shift_right_core #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .data_i  (core_in),
        .shamt_i (shamt),
        .fill_i  (fill),
        .data_o  (core_out)
    );

    assign result = is_left ? core_out_rev : core_out;

    // Next-state: load a new result only when issued; valid depends on in_valid alone
    // so unknown operand bits during idle cycles never reach out_valid.
    always_comb begin
        aluout_d    = aluout_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            aluout_d = result;
        end
    end

    // Output registers; reset clears any in-flight result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            aluout_q    <= aluout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign aluout    = aluout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed table, streaming, reset, random.
// Latency: results checked 1 cycle after issue via an expected-value queue.
// Backpressure: none on the DUT; one operation driven per cycle.
module tb_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  shift_op;
    logic [31:0] alumux1_out;
    logic [31:0] alumux2_out;
    logic [31:0] aluout;
    logic        out_valid;

    int          total;
    int          bad;
    logic [31:0] exp_q [$];
    logic [31:0] last_exp;

    shifter u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .shift_op    (shift_op),
        .alumux1_out (alumux1_out),
        .alumux2_out (alumux2_out),
        .aluout      (aluout),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0]         sh;
        logic signed [31:0] sa;
        sh = b[4:0];
        sa = a;
        case (op)
            2'b01:   return a >> sh;
            2'b10:   return sa >>> sh;
            default: return a << sh;
        endcase
    endfunction

    // Drive one cycle, push the expected result if issued, then check the outputs
    // 1 time unit after the capturing edge.
    task automatic step(input string tag, input logic v, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] e;
        in_valid    = v;
        shift_op    = op;
        alumux1_out = a;
        alumux2_out = b;
        if (v) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        chk({tag, ".vld"}, {31'd0, out_valid}, {31'd0, v});
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".q_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                chk({tag, ".dat"}, aluout, e);
            end
        end else begin
            chk({tag, ".hold"}, aluout, last_exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir_tab [] = '{
        '{2'b00, 32'h0000_0001, 32'd1,  32'h0000_0002},
        '{2'b01, 32'hFFFF_0000, 32'd8,  32'h00FF_FF00},
        '{2'b01, 32'hFFFF_FFFE, 32'd8,  32'h00FF_FFFF},
        '{2'b10, 32'hFFFF_FFFE, 32'd8,  32'hFFFF_FFFF},
        '{2'b10, 32'h7FFF_0000, 32'd8,  32'h007F_FF00},
        '{2'b00, 32'hA5A5_0F0F, 32'd0,  32'hA5A5_0F0F},
        '{2'b01, 32'hA5A5_0F0F, 32'd0,  32'hA5A5_0F0F},
        '{2'b10, 32'hA5A5_0F0F, 32'd0,  32'hA5A5_0F0F},
        '{2'b11, 32'hA5A5_0F0F, 32'd0,  32'hA5A5_0F0F},
        '{2'b10, 32'h8000_0000, 32'd32, 32'h8000_0000},
        '{2'b11, 32'h0000_0001, 32'd4,  32'h0000_0010},
        '{2'b01, 32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000}
    };

    // Amount-masking / edge vectors, also used back-to-back for streaming.
    vec_t edge_tab [] = '{
        '{2'b00, 32'h0000_0001, 32'd33, 32'h0000_0002},
        '{2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF},
        '{2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001}
    };

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic        rv;

        total       = 0;
        bad         = 0;
        last_exp    = 32'd0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        shift_op    = 2'b00;
        alumux1_out = 32'd0;
        alumux2_out = 32'd0;

        #1;
        chk("rst.dat", aluout, 32'd0);
        chk("rst.vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("idle0", 1'b0, 2'b00, 32'd0, 32'd0, 32'd0);

        foreach (dir_tab[i])
            step($sformatf("dir%0d", i), 1'b1, dir_tab[i].op, dir_tab[i].a, dir_tab[i].b,
                 dir_tab[i].exp);

        // Streaming: three consecutive issues, then idle with unknown operands.
        foreach (edge_tab[i])
            step($sformatf("strm%0d", i), 1'b1, edge_tab[i].op, edge_tab[i].a, edge_tab[i].b,
                 edge_tab[i].exp);
        step("strm_idle", 1'b0, 2'bxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 32'd0);
        step("strm_idle2", 1'b0, 2'b00, 32'hDEAD_BEEF, 32'd3, 32'd0);

        // Reset asserted between edges with a result visible and another in flight.
        step("pre_rst", 1'b1, 2'b00, 32'h1234_5678, 32'd4, 32'h2345_6780);
        in_valid    = 1'b1;
        shift_op    = 2'b01;
        alumux1_out = 32'hFFFF_FFFF;
        alumux2_out = 32'd1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.dat", aluout, 32'd0);
        chk("arst.vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold.dat", aluout, 32'd0);
        chk("arst_hold.vld", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        last_exp = 32'd0;
        step("post_rst0", 1'b0, 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0);
        step("post_rst1", 1'b0, 2'b00, 32'h0000_0001, 32'd1, 32'd0);

        // Random vectors against the reference model, mostly issued with some idles.
        for (int n = 0; n < 10000; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            rv  = ($urandom_range(0, 9) != 0);
            step("rnd", rv, rop, ra, rb, ref_shift(rop, ra, rb));
        end

        chk("q_drain", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
